// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, geometry defaults, reset image.
// No logic; no latency; no backpressure.
// Imported by dmem_responder and dmem_array.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    localparam int              DEPTH_DEF     = 16;
    localparam int              DATA_W_DEF    = 8;
    localparam int              INIT_ADDR_DEF = 5;
    localparam logic [7:0]      INIT_DATA_DEF = 8'h0A;

endpackage

// File: rtl/dmem_array.sv
// Data store: register array with synchronous write, combinational read, reset-image load.
// Write commits on the clock edge; read is same-cycle.
// No backpressure; the controller issues at most one access per transaction.
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int                DEPTH     = DEPTH_DEF,
    parameter int                DATA_W    = DATA_W_DEF,
    parameter int                ADDR_W    = $clog2(DEPTH),
    parameter int                INIT_ADDR = INIT_ADDR_DEF,
    parameter logic [DATA_W-1:0] INIT_DATA = INIT_DATA_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= (i == INIT_ADDR) ? INIT_DATA : '0;
            end
        end else if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, LATENCY wait cycles, then a response.
// Handshake to rsp_valid is LATENCY+1 cycles; one transaction per LATENCY+2 cycles back-to-back.
// req_ready is low from acceptance until the response is taken; rsp fields hold while rsp_ready=0.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int                DEPTH     = DEPTH_DEF,
    parameter int                DATA_W    = DATA_W_DEF,
    parameter int                LATENCY   = 2,
    parameter int                INIT_ADDR = INIT_ADDR_DEF,
    parameter logic [DATA_W-1:0] INIT_DATA = INIT_DATA_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [7:0]        req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [7:0]        txn_count
);

    localparam int ADDR_W = $clog2(DEPTH);

    state_t            r_state;
    state_t            w_next_state;
    logic [3:0]        r_wait_cnt;
    logic              r_we;
    logic [7:0]        r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic [7:0]        r_txn;

    logic              w_capture;
    logic              w_access;
    logic              w_acc_we;
    logic [7:0]        w_acc_addr;
    logic [DATA_W-1:0] w_acc_wdata;
    logic              w_in_range;
    logic [DATA_W-1:0] w_mem_rdata;

    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_access     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_capture = 1'b1;
                    if (LATENCY == 0) begin
                        w_access     = 1'b1;
                        w_next_state = ST_RESP;
                    end else begin
                        w_next_state = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (r_wait_cnt == 4'd0) begin
                    w_access     = 1'b1;
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // A zero-latency access happens in IDLE, before the request has been captured.
    assign w_acc_we    = (r_state == ST_IDLE) ? req_we    : r_we;
    assign w_acc_addr  = (r_state == ST_IDLE) ? req_addr  : r_addr;
    assign w_acc_wdata = (r_state == ST_IDLE) ? req_wdata : r_wdata;
    assign w_in_range  = ({1'b0, w_acc_addr} < 9'(DEPTH));

    dmem_array #(
        .DEPTH     (DEPTH),
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .INIT_ADDR (INIT_ADDR),
        .INIT_DATA (INIT_DATA)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_access && w_acc_we && w_in_range),
        .i_addr  (w_acc_addr[ADDR_W-1:0]),
        .i_wdata (w_acc_wdata),
        .o_rdata (w_mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_txn      <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_capture) begin
                r_we       <= req_we;
                r_addr     <= req_addr;
                r_wdata    <= req_wdata;
                r_wait_cnt <= 4'(LATENCY - 1);
            end else if (r_state == ST_WAIT && r_wait_cnt != 4'd0) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end
            if (w_access) begin
                r_err   <= ~w_in_range;
                r_rdata <= (w_in_range && !w_acc_we) ? w_mem_rdata : '0;
            end
            if (r_state == ST_RESP && rsp_ready) begin
                r_txn <= r_txn + 8'd1;
            end
        end
    end

    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
    assign txn_count = r_txn;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance for function/handshake cases
// and a LATENCY=0 instance for single-cycle latency and txn_count wrap.
module tb_dmem_responder;

    logic       clk = 1'b0;
    logic       reset;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    logic       req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
    logic [7:0] req_addr, req_wdata, rsp_rdata, txn_count;

    logic       req_valid0, req_ready0, req_we0, rsp_valid0, rsp_ready0, rsp_err0;
    logic [7:0] req_addr0, req_wdata0, rsp_rdata0, txn_count0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.LATENCY(2)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .txn_count(txn_count)
    );

    dmem_responder #(.LATENCY(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
        .req_addr(req_addr0), .req_wdata(req_wdata0),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
        .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0), .txn_count(txn_count0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction on the LATENCY=2 instance with rsp_ready held high.
    task automatic do_txn(input logic we, input logic [7:0] addr, input logic [7:0] wd,
                          output logic [7:0] rd, output logic er, output int lat,
                          output int hs_cyc);
        int n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        check("req_ready_wait", {31'd0, req_ready}, 32'd1);
        hs_cyc    = cyc;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        rd = rsp_rdata;
        er = rsp_err;
        tick();
    endtask

    initial begin
        logic [7:0] rd;
        logic       er;
        int         lat, hs1, hs2, n;

        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
        req_valid0 = 1'b0; req_we0 = 1'b0; req_addr0 = '0; req_wdata0 = '0; rsp_ready0 = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rdata",     {24'd0, rsp_rdata}, 32'd0);
        check("rst_err",       {31'd0, rsp_err},   32'd0);
        check("rst_txn",       {24'd0, txn_count}, 32'd0);

        // Reset-image load
        do_txn(1'b0, 8'd5, 8'h00, rd, er, lat, hs1);
        check("ld5_lat",   lat, 32'd3);
        check("ld5_rdata", {24'd0, rd}, 32'h0A);
        check("ld5_err",   {31'd0, er}, 32'd0);
        check("ld5_txn",   {24'd0, txn_count}, 32'd1);

        // Store then back-to-back load of the same address
        do_txn(1'b1, 8'd9, 8'h3C, rd, er, lat, hs1);
        check("st9_rdata", {24'd0, rd}, 32'h00);
        check("st9_err",   {31'd0, er}, 32'd0);
        do_txn(1'b0, 8'd9, 8'h00, rd, er, lat, hs2);
        check("b2b_period", hs2 - hs1, 32'd4);
        check("ld9_rdata", {24'd0, rd}, 32'h3C);
        check("ld9_txn",   {24'd0, txn_count}, 32'd3);

        // Out-of-range accesses
        do_txn(1'b0, 8'd16, 8'h00, rd, er, lat, hs1);
        check("ld16_err",   {31'd0, er}, 32'd1);
        check("ld16_rdata", {24'd0, rd}, 32'h00);
        do_txn(1'b1, 8'd200, 8'hFF, rd, er, lat, hs1);
        check("st200_err",   {31'd0, er}, 32'd1);
        check("st200_rdata", {24'd0, rd}, 32'h00);
        do_txn(1'b0, 8'd0, 8'h00, rd, er, lat, hs1);
        check("ld0_rdata", {24'd0, rd}, 32'h00);
        check("ld0_err",   {31'd0, er}, 32'd0);
        check("oor_txn",   {24'd0, txn_count}, 32'd6);

        // Response backpressure with stray requests
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'd5; req_wdata = 8'h00;
        tick();
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", {31'd0, rsp_valid}, 32'd1);
            check("hold_rdata", {24'd0, rsp_rdata}, 32'h0A);
            check("hold_err",   {31'd0, rsp_err},   32'd0);
            check("hold_txn",   {24'd0, txn_count}, 32'd6);
            req_valid = 1'b1; req_we = 1'b1; req_addr = 8'd5; req_wdata = 8'h55;
            tick();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        check("hold_done_txn",   {24'd0, txn_count}, 32'd7);
        check("hold_done_valid", {31'd0, rsp_valid}, 32'd0);
        do_txn(1'b0, 8'd5, 8'h00, rd, er, lat, hs1);
        check("stray_ignored", {24'd0, rd}, 32'h0A);

        // Reset during WAIT abandons the store and reloads the image
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'd5; req_wdata = 8'h77;
        tick();
        req_valid = 1'b0;
        check("abort_in_wait", {31'd0, req_ready}, 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_rdy",   {31'd0, req_ready}, 32'd1);
        check("abort_txn",   {24'd0, txn_count}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
            tick();
        end
        do_txn(1'b0, 8'd5, 8'h00, rd, er, lat, hs1);
        check("abort_ld5", {24'd0, rd}, 32'h0A);
        check("abort_ld_txn", {24'd0, txn_count}, 32'd1);
        do_txn(1'b0, 8'd9, 8'h00, rd, er, lat, hs1);
        check("reload_ld9", {24'd0, rd}, 32'h00);

        // Zero-latency instance: 256 loads, txn_count wraps
        check("l0_rst_txn", {24'd0, txn_count0}, 32'd0);
        for (int i = 0; i < 256; i++) begin
            logic [7:0] a;
            a = 8'(i % 16);
            check("l0_rdy", {31'd0, req_ready0}, 32'd1);
            req_valid0 = 1'b1; req_we0 = 1'b0; req_addr0 = a;
            tick();
            req_valid0 = 1'b0;
            lat = 1;
            while (!rsp_valid0 && lat < 8) begin
                tick();
                lat++;
            end
            check("l0_lat",   lat, 32'd1);
            check("l0_rdata", {24'd0, rsp_rdata0}, (a == 8'd5) ? 32'h0A : 32'h00);
            tick();
            if (i == 254) check("l0_txn255", {24'd0, txn_count0}, 32'd255);
        end
        check("l0_wrap", {24'd0, txn_count0}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
